// File: rtl/wishbone_nn_master.sv
// wishbone_nn_master: Wishbone B4 classic initiator that turns valid/ready commands into single bus cycles.
module wishbone_nn_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t r_state, w_next;
  logic r_rdy, r_we, r_err;
  logic [31:0] r_adr, r_dat, r_rdat;
  logic [3:0] r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic w_acc, w_ack, w_to;
  assign w_acc = cmd_valid_i && r_rdy;
  assign w_ack = r_state == BUS && wbm_ack_i;
  assign w_to = TIMEOUT_CYCLES != 0 && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_acc ? BUS : IDLE;
    else if (r_state == BUS) w_next = (w_ack || w_to) ? RESP : BUS;
    else w_next = rsp_ready_i ? IDLE : RESP;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_rdy <= 1'b0;
      r_we <= 1'b0;
      r_adr <= '0;
      r_dat <= '0;
      r_sel <= '0;
      r_rdat <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_rdy <= w_next == IDLE;
      if (w_acc) begin
        r_we <= cmd_we_i;
        r_adr <= cmd_adr_i;
        r_dat <= cmd_dat_i;
        r_sel <= cmd_sel_i;
        r_cnt <= '0;
      end
      // ack takes priority over a timeout landing on the same edge
      if (r_state == BUS) begin
        if (w_ack) begin
          r_rdat <= r_we ? '0 : wbm_dat_i;
          r_err <= 1'b0;
        end else if (w_to) begin
          r_rdat <= '0;
          r_err <= 1'b1;
        end else if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign cmd_ready_o = r_rdy;
  assign wbm_cyc_o = r_state == BUS;
  assign wbm_stb_o = r_state == BUS;
  assign wbm_we_o = r_we;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_sel_o = r_sel;
  assign rsp_valid_o = r_state == RESP;
  assign rsp_dat_o = r_rdat;
  assign rsp_err_o = r_err;
endmodule

// File: tb/tb_wishbone_nn_master.sv
// tb_wishbone_nn_master: randomized scoreboard bench for the Wishbone initiator.
module tb_wishbone_nn_master;
  localparam int T = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b1;
  logic [31:0] cmd_adr = '0, cmd_dat = '0, s_dat = '0, s_rdata = '0;
  logic [3:0] cmd_sel = '0;
  logic cmd_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid_o, rsp_err_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, rsp_dat_o;
  logic [3:0] wbm_sel_o;
  logic s_ack = 1'b0, spur = 1'b0, s_en = 1'b0, mon_en = 1'b0;
  int s_k = 0, s_n = 0, n_pass = 0, n_chk = 0, cyc_n = 0;
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; int len;} bus_t;
  typedef struct {logic err; logic [31:0] dat;} rsp_t;
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  bus_t cur;
  rsp_t er;
  logic in_bus = 1'b0, held = 1'b0, h_err = 1'b0;
  logic [31:0] h_dat = '0;
  int blen = 0;

  wishbone_nn_master #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(s_ack | spur), .wbm_dat_i(s_dat),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // slave: acks on stb cycle k+1 when enabled; read data is garbage except on the ack cycle
  always @(negedge clk) begin
    if (wbm_cyc_o && wbm_stb_o) s_n = s_n + 1;
    else s_n = 0;
    s_ack = s_en && wbm_cyc_o && wbm_stb_o && s_n == s_k + 1;
    s_dat = s_ack ? s_rdata : $urandom;
  end

  always @(negedge clk) if (mon_en) begin
    chk("cyc_eq_stb", {63'd0, wbm_cyc_o}, {63'd0, wbm_stb_o});
    chk("ready_while_busy", {63'd0, cmd_ready_o && (wbm_cyc_o || rsp_valid_o)}, 64'd0);
    if (wbm_cyc_o) begin
      if (!in_bus) begin
        in_bus = 1'b1;
        blen = 0;
        if (bus_q.size() == 0) chk("bus_unexpected", 64'd1, 64'd0);
        else cur = bus_q.pop_front();
      end
      chk("bus_adr", {32'd0, wbm_adr_o}, {32'd0, cur.adr});
      chk("bus_dat", {32'd0, wbm_dat_o}, {32'd0, cur.dat});
      chk("bus_we_sel", {59'd0, wbm_we_o, wbm_sel_o}, {59'd0, cur.we, cur.sel});
      blen++;
    end else if (in_bus) begin
      in_bus = 1'b0;
      chk("stb_len", 64'(blen), 64'(cur.len));
    end
  end

  always @(negedge clk) if (mon_en) begin
    if (rsp_valid_o && held) chk("rsp_stable", {31'd0, rsp_err_o, rsp_dat_o}, {31'd0, h_err, h_dat});
    if (rsp_valid_o && rsp_ready) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
      else begin
        er = rsp_q.pop_front();
        chk("rsp_dat", {32'd0, rsp_dat_o}, {32'd0, er.dat});
        chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, er.err});
      end
    end
    held = rsp_valid_o && !rsp_ready;
    h_err = rsp_err_o;
    h_dat = rsp_dat_o;
  end

  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int k, input logic en,
                     input logic [31:0] rdata, input int bp);
    logic to;
    int w, acc, len;
    to = !en || (k + 1 > T);
    len = to ? T : k + 1;
    s_k = k;
    s_en = en;
    s_rdata = rdata;
    bus_q.push_back('{we, adr, dat, sel, len});
    rsp_q.push_back('{to, (to || we) ? 32'h0 : rdata});
    rsp_ready = (bp == 0);
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_adr = adr;
    cmd_dat = dat;
    cmd_sel = sel;
    w = 0;
    while (!cmd_ready_o && w < 20) begin @(posedge clk); #1; w++; end
    chk("accept_wait", {63'd0, w < 20}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc = cyc_n;
    w = 0;
    while (!rsp_valid_o && w < 300) begin @(posedge clk); #1; w++; end
    chk("rsp_wait", {63'd0, w < 300}, 64'd1);
    chk("rsp_latency", 64'(cyc_n - acc), 64'(len));
    for (int i = 0; i < bp; i++) begin
      spur = (i == 0);
      cmd_valid = 1'b1;
      cmd_we = 1'($urandom);
      cmd_adr = $urandom;
      @(posedge clk); #1;
      spur = 1'b0;
      chk("bp_no_accept", {63'd0, wbm_cyc_o}, 64'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_drop", {63'd0, rsp_valid_o}, 64'd0);
    chk("ready_back", {63'd0, cmd_ready_o}, 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, {63'd0, cmd_ready_o}, 64'd0);
    chk({tag, "_cyc_stb_we"}, {61'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 64'd0);
    chk({tag, "_adr_sel"}, {28'd0, wbm_adr_o, wbm_sel_o}, 64'd0);
    chk({tag, "_wdat"}, {32'd0, wbm_dat_o}, 64'd0);
    chk({tag, "_rsp"}, {30'd0, rsp_valid_o, rsp_err_o, rsp_dat_o}, 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {63'd0, cmd_ready_o}, 64'd1);
    mon_en = 1'b1;
    txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, 32'h0BAD_0BAD, 0);
    txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 1'b1, 32'h1234_5678, 0);
    txn(1'b0, 32'h3000_0014, 32'h0, 4'hF, 0, 1'b0, 32'h0, 3);
    txn(1'b0, 32'h3000_0018, 32'h0, 4'hF, 3, 1'b1, 32'hA5A5_A5A5, 0);
    txn(1'b0, 32'h3000_001C, 32'h0, 4'h3, 1, 1'b1, 32'hCAFE_F00D, 10);
    mon_en = 1'b0;
    s_k = 5;
    s_en = 1'b1;
    cmd_valid = 1'b1;
    cmd_we = 1'b1;
    cmd_adr = 32'h3000_0020;
    cmd_dat = 32'h5555_AAAA;
    cmd_sel = 4'h3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("rb_cyc", {63'd0, wbm_cyc_o}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("rb");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rb_ready", {63'd0, cmd_ready_o}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("rb_no_rsp", {62'd0, rsp_valid_o, wbm_cyc_o}, 64'd0);
      @(posedge clk); #1;
    end
    mon_en = 1'b1;
    for (int i = 0; i < 30; i++)
      txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 6),
          $urandom_range(0, 9) != 0, $urandom, $urandom_range(0, 3));
    repeat (3) @(posedge clk);
    #1;
    chk("bus_q_left", 64'(bus_q.size()), 64'd0);
    chk("rsp_q_left", 64'(rsp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
